instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage_pkg.sv | 90 +++++++++
 rtl/instr_onehot_dec.sv | 67 ++++++
 rtl/instr_decode_stage.sv | 89 ++++++++
 tb/tb_instr_decode_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings and one-hot bit positions
// used by the decoder and by the downstream control-signal block.
package instr_decode_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ONEHOT_W = 32;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // One-hot bit positions; bit 31 is never assigned
  localparam int B_ADD   = 0;
  localparam int B_ADDU  = 1;
  localparam int B_SUB   = 2;
  localparam int B_SUBU  = 3;
  localparam int B_AND   = 4;
  localparam int B_OR    = 5;
  localparam int B_XOR   = 6;
  localparam int B_NOR   = 7;
  localparam int B_SLT   = 8;
  localparam int B_SLTU  = 9;
  localparam int B_SLL   = 10;
  localparam int B_SRL   = 11;
  localparam int B_SRA   = 12;
  localparam int B_SLLV  = 13;
  localparam int B_SRLV  = 14;
  localparam int B_SRAV  = 15;
  localparam int B_JR    = 16;
  localparam int B_ADDI  = 17;
  localparam int B_ADDIU = 18;
  localparam int B_ANDI  = 19;
  localparam int B_ORI   = 20;
  localparam int B_XORI  = 21;
  localparam int B_LW    = 22;
  localparam int B_SW    = 23;
  localparam int B_BEQ   = 24;
  localparam int B_BNE   = 25;
  localparam int B_SLTI  = 26;
  localparam int B_SLTIU = 27;
  localparam int B_LUI   = 28;
  localparam int B_J     = 29;
  localparam int B_JAL   = 30;

  typedef struct packed {
    logic [ONEHOT_W-1:0] onehot;
    logic                illegal;
  } dec_t;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [INSTR_W-1:0] w);
    return w[5:0];
  endfunction

endpackage

// File: rtl/instr_onehot_dec.sv
// Combinational MIPS decoder: one-hot instruction class plus illegal flag.
module instr_onehot_dec
  import instr_decode_stage_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [ONEHOT_W-1:0] out_i,
  output logic                illegal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  dec_t       dec;
  logic       unused_fields;

  assign opcode = opcode_of(instr_i);
  assign funct  = funct_of(instr_i);
  // Register/shamt/immediate fields do not affect classification
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  dec.onehot[B_ADD]  = 1'b1;
          FN_ADDU: dec.onehot[B_ADDU] = 1'b1;
          FN_SUB:  dec.onehot[B_SUB]  = 1'b1;
          FN_SUBU: dec.onehot[B_SUBU] = 1'b1;
          FN_AND:  dec.onehot[B_AND]  = 1'b1;
          FN_OR:   dec.onehot[B_OR]   = 1'b1;
          FN_XOR:  dec.onehot[B_XOR]  = 1'b1;
          FN_NOR:  dec.onehot[B_NOR]  = 1'b1;
          FN_SLT:  dec.onehot[B_SLT]  = 1'b1;
          FN_SLTU: dec.onehot[B_SLTU] = 1'b1;
          FN_SLL:  dec.onehot[B_SLL]  = 1'b1;
          FN_SRL:  dec.onehot[B_SRL]  = 1'b1;
          FN_SRA:  dec.onehot[B_SRA]  = 1'b1;
          FN_SLLV: dec.onehot[B_SLLV] = 1'b1;
          FN_SRLV: dec.onehot[B_SRLV] = 1'b1;
          FN_SRAV: dec.onehot[B_SRAV] = 1'b1;
          FN_JR:   dec.onehot[B_JR]   = 1'b1;
          default: dec.onehot = '0;
        endcase
      end
      OP_ADDI:  dec.onehot[B_ADDI]  = 1'b1;
      OP_ADDIU: dec.onehot[B_ADDIU] = 1'b1;
      OP_ANDI:  dec.onehot[B_ANDI]  = 1'b1;
      OP_ORI:   dec.onehot[B_ORI]   = 1'b1;
      OP_XORI:  dec.onehot[B_XORI]  = 1'b1;
      OP_LW:    dec.onehot[B_LW]    = 1'b1;
      OP_SW:    dec.onehot[B_SW]    = 1'b1;
      OP_BEQ:   dec.onehot[B_BEQ]   = 1'b1;
      OP_BNE:   dec.onehot[B_BNE]   = 1'b1;
      OP_SLTI:  dec.onehot[B_SLTI]  = 1'b1;
      OP_SLTIU: dec.onehot[B_SLTIU] = 1'b1;
      OP_LUI:   dec.onehot[B_LUI]   = 1'b1;
      OP_J:     dec.onehot[B_J]     = 1'b1;
      OP_JAL:   dec.onehot[B_JAL]   = 1'b1;
      default:  dec.onehot = '0;
    endcase
    dec.illegal = (dec.onehot == '0);
  end

  assign out_i     = dec.onehot;
  assign illegal_o = dec.illegal;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode pipeline stage: one-entry valid/ready register around the one-hot
// decoder, with flush, synchronous reset and a handoff counter.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [INSTR_W-1:0]  in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_i,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [INSTR_W-1:0]  out_pc,
  output logic                out_illegal,
  output logic [31:0]         dec_count
);

  logic [ONEHOT_W-1:0] dec_onehot;
  logic                dec_illegal;

  logic                valid_q, valid_d;
  logic [ONEHOT_W-1:0] onehot_q, onehot_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [INSTR_W-1:0]  pc_q, pc_d;
  logic                illegal_q, illegal_d;
  logic [31:0]         count_q, count_d;

  logic handoff;
  logic load;

  instr_onehot_dec u_dec (
    .instr_i   (in_instr),
    .out_i     (dec_onehot),
    .illegal_o (dec_illegal)
  );

  assign in_ready = (~valid_q | out_ready) & ~rst;
  assign handoff  = valid_q & out_ready;
  // Flush wins over a simultaneous acceptance
  assign load     = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d   = valid_q;
    onehot_d  = onehot_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    count_d   = count_q + {31'd0, handoff};
    if (load) begin
      valid_d   = 1'b1;
      onehot_d  = dec_onehot;
      instr_d   = in_instr;
      pc_d      = in_pc;
      illegal_d = dec_illegal;
    end else if (flush || handoff) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      instr_q   <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_i       = onehot_q;
  assign out_instr   = instr_q;
  assign out_pc      = pc_q;
  assign out_illegal = illegal_q;
  assign dec_count   = count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed plus randomized bench for instr_decode_stage against a table-driven
// reference model of the decode and handshake rules.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_i;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [31:0] dec_count;

  instr_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_i       (out_i),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .dec_count   (dec_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Position in these tables is the one-hot bit (funct: 0..16, opcode: 17..30)
  bit [5:0] fn_codes [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  bit [5:0] op_codes [14] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                              6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03};
  int fn_map [bit [5:0]];
  int op_map [bit [5:0]];

  bit        m_valid = 1'b0;
  bit [31:0] m_i = '0, m_instr = '0, m_pc = '0, m_cnt = '0;
  bit        m_ill = 1'b0;

  function automatic bit [31:0] ref_dec(input bit [31:0] w);
    bit [5:0] op;
    bit [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'd0) return fn_map.exists(fn) ? (32'd1 << fn_map[fn]) : 32'd0;
    return op_map.exists(op) ? (32'd1 << op_map[op]) : 32'd0;
  endfunction

  function automatic bit [31:0] rand_word();
    bit [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: begin w[31:26] = 6'd0; w[5:0] = fn_codes[$urandom_range(0, 16)]; end
      1: w[31:26] = op_codes[$urandom_range(0, 13)];
      2: w[31:26] = 6'd0;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit iv, input bit orr,
                      input bit [31:0] ins, input bit [31:0] p);
    bit handoff;
    bit accept;
    rst = r; flush = f; in_valid = iv; out_ready = orr; in_instr = ins; in_pc = p;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || orr) && !r});
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_i = 0; m_instr = 0; m_pc = 0; m_ill = 0; m_cnt = 0;
    end else begin
      handoff = m_valid && orr;
      accept  = iv && (!m_valid || orr) && !f;
      if (handoff) m_cnt = m_cnt + 1;
      if (accept) begin
        m_valid = 1; m_instr = ins; m_pc = p; m_i = ref_dec(ins); m_ill = (m_i == 0);
      end else if (f || handoff) begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid",   {31'd0, out_valid},   {31'd0, m_valid});
    chk("out_i",       out_i,                m_i);
    chk("out_instr",   out_instr,            m_instr);
    chk("out_pc",      out_pc,               m_pc);
    chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
    chk("dec_count",   dec_count,            m_cnt);
  endtask

  initial begin
    bit [31:0] c0;
    for (int i = 0; i < 17; i++) fn_map[fn_codes[i]] = i;
    for (int i = 0; i < 14; i++) op_map[op_codes[i]] = 17 + i;

    step(1, 0, 1, 1, 32'h00221820, 32'h0);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", dec_count, 32'd0);

    // add, then handoff
    step(0, 0, 1, 1, 32'h00221820, 32'h0000_0100);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_oi", out_i, 32'h0000_0001);
    chk("add_ill", {31'd0, out_illegal}, 32'd0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk("add_count", dec_count, 32'd1);

    // lw then jal back-to-back
    step(0, 0, 1, 1, 32'h8C220004, 32'h0000_0104);
    chk("lw_oi", out_i, 32'h0040_0000);
    step(0, 0, 1, 1, 32'h0C000010, 32'h0000_0108);
    chk("jal_oi", out_i, 32'h4000_0000);
    chk("jal_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // illegal and all-zero word
    step(0, 0, 1, 1, 32'h7C000000, 32'h0000_0200);
    chk("ill_oi", out_i, 32'd0);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 1, 1, 32'h00000000, 32'h0000_0204);
    chk("nop_oi", out_i, 32'h0000_0400);
    chk("nop_ill", {31'd0, out_illegal}, 32'd0);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // backpressure for 3 cycles, then release
    step(0, 0, 1, 0, 32'h012A4022, 32'h0000_0300);
    c0 = dec_count;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 32'h35080001, 32'h0000_0304);
      chk("bp_instr", out_instr, 32'h012A4022);
      chk("bp_count", dec_count, c0);
    end
    step(0, 0, 1, 1, 32'h35080001, 32'h0000_0304);
    chk("rel_instr", out_instr, 32'h35080001);
    chk("rel_count", dec_count, c0 + 1);

    // flush while stalled: flushed word never loads
    step(0, 1, 1, 0, 32'h2129FFFF, 32'h0000_0308);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_count", dec_count, c0 + 1);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("fl_instr", out_instr, 32'h35080001);

    // bring count to 5 with a held word, then reset
    step(1, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, rand_word(), 32'h400 + 4 * i);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("pre_rst_count", dec_count, 32'd5);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    step(1, 0, 1, 1, 32'h00221820, 32'h0);
    chk("rst2_count", dec_count, 32'd0);
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_oi", out_i, 32'd0);
    chk("rst2_instr", out_instr, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           rand_word(), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
